// File: rtl/pico_sdram_bridge_pkg.sv
// rtl/pico_sdram_bridge_pkg.sv - register map, status/command bits and FSM states for pico_sdram_bridge
package pico_sdram_bridge_pkg;

    localparam logic [3:0] OFS_ADDR0  = 4'd0;
    localparam logic [3:0] OFS_ADDR1  = 4'd1;
    localparam logic [3:0] OFS_ADDR2  = 4'd2;
    localparam logic [3:0] OFS_DATA0  = 4'd4;
    localparam logic [3:0] OFS_DATA1  = 4'd5;
    localparam logic [3:0] OFS_DATA2  = 4'd6;
    localparam logic [3:0] OFS_DATA3  = 4'd7;
    localparam logic [3:0] OFS_CMD    = 4'd8;
    localparam logic [3:0] OFS_STATUS = 4'd9;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_OVERRUN = 3;

    localparam int CMD_WE      = 0;
    localparam int CMD_AUTOINC = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    // Offsets whose writes are frozen (and flag overrun) while a request is outstanding
    function automatic logic is_cfg_ofs(input logic [3:0] ofs);
        return (ofs <= OFS_CMD) && (ofs != 4'd3);
    endfunction

endpackage

// File: rtl/pico_sdram_bridge.sv
// rtl/pico_sdram_bridge.sv - byte-wide PicoBlaze port-I/O front end issuing single 32-bit SDRAM requests
module pico_sdram_bridge
    import pico_sdram_bridge_pkg::*;
#(
    parameter logic [3:0] BASE_NIBBLE    = 4'hC,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         TIMEOUT_W      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  port_id,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic [7:0]  out_port,
    output logic [7:0]  in_port,
    output logic        sdram_stb,
    output logic        sdram_we,
    output logic [23:0] sdram_addr,
    output logic [31:0] sdram_wdata,
    input  logic [31:0] sdram_rdata,
    input  logic        sdram_ack
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [23:0]          addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 we;
    logic                 autoinc;
    logic                 done;
    logic                 timeout;
    logic                 overrun;
    logic [TIMEOUT_W-1:0] count;

    logic       sel;
    logic [3:0] offset;
    logic       wr;
    logic       busy;
    logic [7:0] status;
    logic       unused_read_strobe;

    assign sel    = (port_id[7:4] == BASE_NIBBLE);
    assign offset = port_id[3:0];
    assign wr     = write_strobe & sel;
    assign busy   = (state != S_IDLE);

    // Reads are side-effect free, so the strobe carries no information here
    assign unused_read_strobe = read_strobe;

    assign sdram_addr  = addr;
    assign sdram_wdata = wdata;
    assign sdram_we    = we;

    always_comb begin
        status              = 8'h00;
        status[ST_BUSY]     = busy;
        status[ST_DONE]     = done;
        status[ST_TIMEOUT]  = timeout;
        status[ST_OVERRUN]  = overrun;
    end

    always_comb begin
        in_port = 8'h00;
        if (sel) begin
            case (offset)
                OFS_ADDR0:  in_port = addr[7:0];
                OFS_ADDR1:  in_port = addr[15:8];
                OFS_ADDR2:  in_port = addr[23:16];
                OFS_DATA0:  in_port = rdata[7:0];
                OFS_DATA1:  in_port = rdata[15:8];
                OFS_DATA2:  in_port = rdata[23:16];
                OFS_DATA3:  in_port = rdata[31:24];
                OFS_STATUS: in_port = status;
                default:    in_port = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            we        <= 1'b0;
            autoinc   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
            count     <= '0;
            sdram_stb <= 1'b0;
        end else begin
            // W1C first so that any hardware set later in this block takes priority
            if (wr && offset == OFS_STATUS) begin
                if (out_port[ST_DONE])    done    <= 1'b0;
                if (out_port[ST_TIMEOUT]) timeout <= 1'b0;
                if (out_port[ST_OVERRUN]) overrun <= 1'b0;
            end
            if (wr && busy && is_cfg_ofs(offset)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (wr) begin
                        case (offset)
                            OFS_ADDR0: addr[7:0]    <= out_port;
                            OFS_ADDR1: addr[15:8]   <= out_port;
                            OFS_ADDR2: addr[23:16]  <= out_port;
                            OFS_DATA0: wdata[7:0]   <= out_port;
                            OFS_DATA1: wdata[15:8]  <= out_port;
                            OFS_DATA2: wdata[23:16] <= out_port;
                            OFS_DATA3: wdata[31:24] <= out_port;
                            OFS_CMD: begin
                                we        <= out_port[CMD_WE];
                                autoinc   <= out_port[CMD_AUTOINC];
                                done      <= 1'b0;
                                timeout   <= 1'b0;
                                count     <= '0;
                                sdram_stb <= 1'b1;
                                state     <= S_REQ;
                            end
                            default: ;
                        endcase
                    end
                end
                S_REQ: begin
                    count <= count + TIMEOUT_W'(1);
                    if (sdram_ack) begin
                        if (!we) rdata <= sdram_rdata;
                        if (autoinc) addr <= addr + 24'd1;
                        done      <= 1'b1;
                        sdram_stb <= 1'b0;
                        state     <= S_RECOVER;
                    end else if (count == TO_LAST) begin
                        timeout   <= 1'b1;
                        done      <= 1'b0;
                        sdram_stb <= 1'b0;
                        state     <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    state <= S_IDLE;
                end
                default: begin
                    sdram_stb <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pico_sdram_bridge.sv
// tb/tb_pico_sdram_bridge.sv - self-checking bench for pico_sdram_bridge
module tb_pico_sdram_bridge;

    localparam int TO_CYC = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  port_id = 8'h00;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  out_port = 8'h00;
    logic [7:0]  in_port;
    logic        sdram_stb;
    logic        sdram_we;
    logic [23:0] sdram_addr;
    logic [31:0] sdram_wdata;
    logic [31:0] sdram_rdata = 32'h0;
    logic        sdram_ack = 1'b0;

    pico_sdram_bridge #(
        .BASE_NIBBLE   (4'hC),
        .TIMEOUT_CYCLES(TO_CYC),
        .TIMEOUT_W     (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_id     (port_id),
        .write_strobe(write_strobe),
        .read_strobe (read_strobe),
        .out_port    (out_port),
        .in_port     (in_port),
        .sdram_stb   (sdram_stb),
        .sdram_we    (sdram_we),
        .sdram_addr  (sdram_addr),
        .sdram_wdata (sdram_wdata),
        .sdram_rdata (sdram_rdata),
        .sdram_ack   (sdram_ack)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic       do_wr;
        logic [7:0] pid;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    req_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   run_len = 0;
    int   last_len = 0;
    logic prev_stb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request monitor: pops the expected request on every stb rising edge, tracks stb pulse length
    always @(negedge clk) begin
        if (sdram_stb) begin
            if (!prev_stb) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_request: got addr %h we %b expected none", sdram_addr, sdram_we);
                end else begin
                    req_t r;
                    r = sb.pop_front();
                    chk("req_we", {31'b0, sdram_we}, {31'b0, r.we});
                    chk("req_addr", {8'b0, sdram_addr}, {8'b0, r.addr});
                    chk("req_wdata", sdram_wdata, r.wdata);
                end
            end
            run_len++;
        end else begin
            if (prev_stb) last_len = run_len;
            run_len = 0;
        end
        prev_stb = sdram_stb;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] pid, input logic [7:0] d);
        port_id = pid;
        out_port = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic io_read(input logic [7:0] pid, output logic [7:0] d);
        port_id = pid;
        read_strobe = 1'b1;
        #1;
        d = in_port;
        read_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] pid, input logic [7:0] exp);
        logic [7:0] d;
        io_read(pid, d);
        chk(name, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic issue(input logic [7:0] cmd, input req_t exp);
        sb.push_back(exp);
        io_write(8'hC8, cmd);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 8'hC0, 8'h5A, 8'h5A};
        vecs[1]  = '{1'b1, 8'hC1, 8'hA5, 8'hA5};
        vecs[2]  = '{1'b1, 8'hC2, 8'h3C, 8'h3C};
        vecs[3]  = '{1'b0, 8'hC3, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'hC3, 8'hFF, 8'h00};
        vecs[5]  = '{1'b0, 8'hC4, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 8'hC8, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'hC9, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 8'h40, 8'h77, 8'h00};
        vecs[9]  = '{1'b0, 8'hC0, 8'h00, 8'h5A};
        vecs[10] = '{1'b1, 8'hCA, 8'h12, 8'h00};
        vecs[11] = '{1'b1, 8'hC4, 8'h99, 8'h00};

        repeat (3) tick();
        chk("rst_stb_async", {31'b0, sdram_stb}, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_stb", {31'b0, sdram_stb}, 32'h0);
        chk("rst_we", {31'b0, sdram_we}, 32'h0);
        chk("rst_addr", {8'b0, sdram_addr}, 32'h0);
        chk("rst_wdata", sdram_wdata, 32'h0);
        for (int p = 0; p < 10; p++) begin
            rd_chk($sformatf("rst_port%0d", p), 8'hC0 | 8'(p), 8'h00);
            tick();
        end

        // Register map vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) io_write(vecs[i].pid, vecs[i].data);
            rd_chk($sformatf("vec%0d_port%h", i, vecs[i].pid), vecs[i].pid, vecs[i].exp);
            tick();
        end
        chk("vec_sdram_addr", {8'b0, sdram_addr}, 32'h003CA55A);

        // Write request, ack in the fifth stb cycle
        io_write(8'hC0, 8'h23); io_write(8'hC1, 8'h01); io_write(8'hC2, 8'h00);
        io_write(8'hC4, 8'hEF); io_write(8'hC5, 8'hBE); io_write(8'hC6, 8'hAD); io_write(8'hC7, 8'hDE);
        issue(8'h01, '{1'b1, 24'h000123, 32'hDEADBEEF});
        chk("wr_stb_latency", {31'b0, sdram_stb}, 32'h1);
        repeat (4) tick();
        chk("wr_stb_held", {31'b0, sdram_stb}, 32'h1);
        sdram_ack = 1'b1;
        sdram_rdata = 32'h55555555;
        tick();
        sdram_ack = 1'b0;
        chk("wr_stb_len", last_len, 5);
        chk("wr_stb_drop", {31'b0, sdram_stb}, 32'h0);
        rd_chk("wr_status_a1", 8'hC9, 8'h03);
        tick();
        rd_chk("wr_status_a2", 8'hC9, 8'h02);
        rd_chk("wr_rdata_kept", 8'hC4, 8'h00);
        tick();

        // Read with autoinc at top of address space
        io_write(8'hC0, 8'hFF); io_write(8'hC1, 8'hFF); io_write(8'hC2, 8'hFF);
        issue(8'h02, '{1'b0, 24'hFFFFFF, 32'hDEADBEEF});
        sdram_ack = 1'b1;
        sdram_rdata = 32'h11223344;
        tick();
        sdram_ack = 1'b0;
        tick();
        rd_chk("rd_byte0", 8'hC4, 8'h44);
        rd_chk("rd_byte3", 8'hC7, 8'h11);
        rd_chk("rd_status", 8'hC9, 8'h02);
        tick();
        rd_chk("wrap_addr0", 8'hC0, 8'h00);
        rd_chk("wrap_addr1", 8'hC1, 8'h00);
        rd_chk("wrap_addr2", 8'hC2, 8'h00);
        tick();

        // Timeout, then a late ack that must be ignored
        issue(8'h00, '{1'b0, 24'h000000, 32'hDEADBEEF});
        for (int i = 0; i < 100 && sdram_stb; i++) tick();
        chk("to_stb_fell", {31'b0, sdram_stb}, 32'h0);
        chk("to_stb_len", last_len, TO_CYC);
        tick();
        rd_chk("to_status", 8'hC9, 8'h04);
        rd_chk("to_rdata_kept", 8'hC4, 8'h44);
        sdram_ack = 1'b1;
        sdram_rdata = 32'hAABBCCDD;
        tick();
        sdram_ack = 1'b0;
        tick();
        rd_chk("late_ack_rdata", 8'hC4, 8'h44);
        rd_chk("late_ack_status", 8'hC9, 8'h04);
        chk("late_ack_stb", {31'b0, sdram_stb}, 32'h0);

        // Writes while busy are frozen and raise overrun
        issue(8'h01, '{1'b1, 24'h000000, 32'hDEADBEEF});
        io_write(8'hC0, 8'h55);
        io_write(8'hC8, 8'h03);
        chk("ovr_addr_frozen", {8'b0, sdram_addr}, 32'h0);
        rd_chk("ovr_status_req", 8'hC9, 8'h09);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        repeat (4) tick();
        chk("ovr_no_second_req", {31'b0, sdram_stb}, 32'h0);
        rd_chk("ovr_status_done", 8'hC9, 8'h0A);
        rd_chk("ovr_addr_reg", 8'hC0, 8'h00);
        tick();

        // Ack in the same cycle the counter reaches its limit
        issue(8'h00, '{1'b0, 24'h000000, 32'hDEADBEEF});
        repeat (TO_CYC - 1) tick();
        sdram_ack = 1'b1;
        sdram_rdata = 32'hCAFEF00D;
        tick();
        sdram_ack = 1'b0;
        chk("race_stb_len", last_len, TO_CYC);
        tick();
        rd_chk("race_status", 8'hC9, 8'h0A);
        rd_chk("race_rdata", 8'hC4, 8'h0D);
        io_write(8'hC9, 8'h0E);
        rd_chk("w1c_status", 8'hC9, 8'h00);
        tick();

        // W1C of done in the same cycle the ack sets it
        issue(8'h00, '{1'b0, 24'h000000, 32'hDEADBEEF});
        sdram_ack = 1'b1;
        sdram_rdata = 32'h01020304;
        io_write(8'hC9, 8'h02);
        sdram_ack = 1'b0;
        tick();
        rd_chk("w1c_vs_set", 8'hC9, 8'h02);
        rd_chk("w1c_vs_set_rdata", 8'hC4, 8'h04);
        tick();

        // Reset in the middle of a request
        io_write(8'hC1, 8'h44);
        issue(8'h01, '{1'b1, 24'h004400, 32'hDEADBEEF});
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_stb_async", {31'b0, sdram_stb}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_we", {31'b0, sdram_we}, 32'h0);
        chk("midrst_addr", {8'b0, sdram_addr}, 32'h0);
        chk("midrst_wdata", sdram_wdata, 32'h0);
        for (int p = 0; p < 10; p++) begin
            rd_chk($sformatf("midrst_port%0d", p), 8'hC0 | 8'(p), 8'h00);
            tick();
        end
        repeat (3) tick();
        chk("midrst_no_replay", {31'b0, sdram_stb}, 32'h0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
